// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: instruction-cache request/response, decode
// handoff and redirect inputs. The master modport is the fetch queue.
interface ifetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  if2ic_en;
    logic [ADDR_WIDTH-1:0] if2ic_pc;
    logic                  ic2if_hit;
    logic [INST_WIDTH-1:0] ic2if_inst;
    logic                  if2dec;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic [INST_WIDTH-1:0] inst_out;
    logic                  dec_ready;
    logic                  decUpd;
    logic [ADDR_WIDTH-1:0] dec2if_pc;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;

    modport master (
        output if2ic_en, if2ic_pc, if2dec, pc_out, inst_out,
        input  ic2if_hit, ic2if_inst, dec_ready, decUpd, dec2if_pc, flush, flush_pc
    );

    modport slave (
        input  if2ic_en, if2ic_pc, if2dec, pc_out, inst_out,
        output ic2if_hit, ic2if_inst, dec_ready, decUpd, dec2if_pc, flush, flush_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding I-cache request at a time,
// responses pushed into a small FIFO of {pc, inst} that feeds decode.
// Redirects (flush beats decUpd) clear the queue; a redirect that lands
// while a request is in flight moves to DROP so the stale response is eaten.
// Optional feature macro: IFQ_STATIC_JAL_EN -- follow JAL targets at fetch.
module ifetch_queue #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic           clk,
    input  logic           rst_in,
    input  logic           rdy_in,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] fpc, fpc_nxt, fetch_next, redir_pc;
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count, count_nxt, count_post;
    logic                  redirect, push, pop;

    logic [ADDR_WIDTH-1:0] pc_q   [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0] inst_q [QUEUE_DEPTH];

    assign bus.if2ic_en = (state != IDLE);
    assign bus.if2ic_pc = fpc;
    assign bus.if2dec   = (count != '0);
    assign bus.pc_out   = bus.if2dec ? pc_q[head]   : '0;
    assign bus.inst_out = bus.if2dec ? inst_q[head] : '0;

    // Address following the word being pushed this cycle.
    always_comb begin
`ifdef IFQ_STATIC_JAL_EN
        logic [20:0] jimm;
        jimm = {bus.ic2if_inst[31], bus.ic2if_inst[19:12], bus.ic2if_inst[20],
                bus.ic2if_inst[30:21], 1'b0};
        if (bus.ic2if_inst[6:0] == 7'b1101111)
            fetch_next = fpc + {{(ADDR_WIDTH-21){jimm[20]}}, jimm};
        else
            fetch_next = fpc + ADDR_WIDTH'(4);
`else
        fetch_next = fpc + ADDR_WIDTH'(4);
`endif
    end

    // Queue bookkeeping and request FSM next-state.
    always_comb begin
        redirect   = bus.flush || bus.decUpd;
        redir_pc   = bus.flush ? bus.flush_pc : bus.dec2if_pc;
        push       = (state == REQ) && bus.ic2if_hit && !redirect;
        pop        = bus.if2dec && bus.dec_ready && !redirect;
        count_post = count + CW'(push) - CW'(pop);
        count_nxt  = redirect ? '0 : count_post;
        fpc_nxt    = redirect ? redir_pc : (push ? fetch_next : fpc);
        state_nxt  = state;
        case (state)
            IDLE: if (redirect || count < FULL) state_nxt = REQ;
            REQ: begin
                if (redirect)
                    // A same-cycle response retires the old request.
                    state_nxt = bus.ic2if_hit ? REQ : DROP;
                else if (bus.ic2if_hit)
                    state_nxt = (count_post < FULL) ? REQ : IDLE;
            end
            DROP: if (!redirect && bus.ic2if_hit) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers; rdy_in low freezes everything.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            fpc   <= RESET_PC;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (rdy_in) begin
            state <= state_nxt;
            fpc   <= fpc_nxt;
            count <= count_nxt;
            if (redirect) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (pop)  head <= head + 1'b1;
                if (push) tail <= tail + 1'b1;
            end
        end
    end

    // Entry storage; contents are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (rdy_in && push) begin
            pc_q[tail]   <= fpc;
            inst_q[tail] <= bus.ic2if_inst;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue. Stimulus pushes expected {pc, inst}
// for every accepted response into a scoreboard; a negedge monitor pops
// and compares whenever decode takes the head. Control/state checks are
// made inline one step after each edge.
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic rst_in, rdy_in;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] sb [$];

`ifdef IFQ_STATIC_JAL_EN
    // J-immediate of 0x0100006F is +0x10 (imm[10:1] = 8).
    localparam logic [31:0] JAL_NEXT = 32'h30;
`else
    localparam logic [31:0] JAL_NEXT = 32'h24;
`endif

    ifetch_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

    ifetch_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return 32'h1000_0000 | pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Answer the outstanding request; acc says whether it should be queued.
    task automatic hit(input logic [31:0] pc, input logic [31:0] inst, input bit acc);
        chk("req_en", 32'(bus.if2ic_en), 32'd1);
        chk("req_pc", bus.if2ic_pc, pc);
        bus.ic2if_hit  = 1'b1;
        bus.ic2if_inst = inst;
        if (acc) sb.push_back({pc, inst});
        step();
        bus.ic2if_hit = 1'b0;
    endtask

    // Monitor: compare every head that decode actually accepts.
    always @(negedge clk) begin
        if (rst_in && rdy_in && bus.if2dec && bus.dec_ready && !bus.flush && !bus.decUpd) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: got pc %h with nothing expected", bus.pc_out);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({bus.pc_out, bus.inst_out} !== e) begin
                    bad++;
                    $display("FAIL dec_head: got %h/%h expected %h/%h",
                             bus.pc_out, bus.inst_out, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1;
        bus.ic2if_hit = 1'b0; bus.ic2if_inst = '0; bus.dec_ready = 1'b0;
        bus.decUpd = 1'b0; bus.dec2if_pc = '0; bus.flush = 1'b0; bus.flush_pc = '0;
        repeat (2) step();
        chk("rst_en", 32'(bus.if2ic_en), 32'd0);
        chk("rst_dec", 32'(bus.if2dec), 32'd0);
        chk("rst_pc_out", bus.pc_out, 32'h0);
        chk("rst_inst_out", bus.inst_out, 32'h0);
        chk("rst_ic_pc", bus.if2ic_pc, 32'h0);
        rst_in = 1'b1;
        chk("rel_en", 32'(bus.if2ic_en), 32'd0);
        step();

        // Streaming with decode always ready.
        bus.dec_ready = 1'b1;
        hit(32'h0, iw(32'h0), 1);
        chk("first_dec", 32'(bus.if2dec), 32'd1);
        chk("first_pc", bus.pc_out, 32'h0);
        hit(32'h4, iw(32'h4), 1);
        hit(32'h8, iw(32'h8), 1);
        hit(32'hC, iw(32'hC), 1);
        step();
        chk("drain_dec", 32'(bus.if2dec), 32'd0);

        // Fill to full with decode stalled, then release one slot.
        bus.dec_ready = 1'b0;
        hit(32'h10, iw(32'h10), 1);
        hit(32'h14, iw(32'h14), 1);
        hit(32'h18, iw(32'h18), 1);
        hit(32'h1C, iw(32'h1C), 1);
        chk("full_en", 32'(bus.if2ic_en), 32'd0);
        chk("full_head", bus.pc_out, 32'h10);
        chk("full_inst", bus.inst_out, iw(32'h10));
        repeat (2) step();
        chk("idle_en", 32'(bus.if2ic_en), 32'd0);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        chk("pop_en", 32'(bus.if2ic_en), 32'd0);
        step();
        hit(32'h20, iw(32'h20), 1);
        chk("refill_en", 32'(bus.if2ic_en), 32'd0);
        chk("refill_head", bus.pc_out, 32'h14);

        // Freeze: everything asserted but rdy_in low.
        rdy_in = 1'b0; bus.dec_ready = 1'b1; bus.ic2if_hit = 1'b1;
        bus.ic2if_inst = 32'hDEAD; bus.flush = 1'b1; bus.flush_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_dec", 32'(bus.if2dec), 32'd1);
            chk("frz_head", bus.pc_out, 32'h14);
            chk("frz_en", 32'(bus.if2ic_en), 32'd0);
        end
        rdy_in = 1'b1; bus.ic2if_hit = 1'b0; bus.flush = 1'b0;
        repeat (4) step();
        chk("resume_dec", 32'(bus.if2dec), 32'd0);

        // Flush with a request in flight -> stale response dropped.
        bus.flush = 1'b1; bus.flush_pc = 32'h100;
        step();
        bus.flush = 1'b0;
        chk("drop_en", 32'(bus.if2ic_en), 32'd1);
        chk("drop_pc", bus.if2ic_pc, 32'h100);
        chk("drop_dec", 32'(bus.if2dec), 32'd0);
        hit(32'h100, 32'hDEAD, 0);
        chk("dropped_dec", 32'(bus.if2dec), 32'd0);
        hit(32'h100, iw(32'h100), 1);
        chk("after_drop_pc", bus.pc_out, 32'h100);
        step();

        // flush and decUpd together with a hit: flush wins, hit discarded.
        bus.flush = 1'b1; bus.flush_pc = 32'h80;
        bus.decUpd = 1'b1; bus.dec2if_pc = 32'h40;
        hit(32'h104, 32'hBEEF, 0);
        bus.flush = 1'b0; bus.decUpd = 1'b0;
        chk("both_dec", 32'(bus.if2dec), 32'd0);
        hit(32'h80, iw(32'h80), 1);
        step();

        // Redirect to 0x20 then push a JAL there.
        bus.decUpd = 1'b1; bus.dec2if_pc = 32'h20;
        hit(32'h84, 32'hBEEF, 0);
        bus.decUpd = 1'b0;
        hit(32'h20, 32'h0100006F, 1);
        hit(JAL_NEXT, iw(JAL_NEXT), 1);
        step();

        // Address wrap-around.
        bus.decUpd = 1'b1; bus.dec2if_pc = 32'hFFFF_FFFC;
        hit(JAL_NEXT + 32'h4, 32'hBEEF, 0);
        bus.decUpd = 1'b0;
        hit(32'hFFFF_FFFC, iw(32'hFFFF_FFFC), 1);
        chk("wrap_pc", bus.if2ic_pc, 32'h0);
        step();

        // Asynchronous reset with a request outstanding.
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_en", 32'(bus.if2ic_en), 32'd0);
        chk("arst_dec", 32'(bus.if2dec), 32'd0);
        step();
        rst_in = 1'b1;
        chk("arst_rel_en", 32'(bus.if2ic_en), 32'd0);
        step();
        chk("arst_req_en", 32'(bus.if2ic_en), 32'd1);
        chk("arst_req_pc", bus.if2ic_pc, 32'h0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
